// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: OCP-style register bus between a bus master and the UART transmitter.
interface uart_tx_fifo_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] MAddr;
    logic [2:0] MCmd;
    logic [DATA_WIDTH-1:0] MData;
    logic [BEN_WIDTH-1:0] MByteEn;
    logic SCmdAccept;
    logic [DATA_WIDTH-1:0] SData;
    logic [1:0] SResp;
    modport master (output MAddr, MCmd, MData, MByteEn, input SCmdAccept, SData, SResp);
    modport slave (input MAddr, MCmd, MData, MByteEn, output SCmdAccept, SData, SResp);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: OCP register slave feeding an 8N1 serial transmitter through a byte FIFO.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET = 16'd16
) (
    input  logic clk,
    input  logic rst,
    uart_tx_fifo_if.slave bus,
    output logic o_txd,
    output logic o_intr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp, count;
    logic [15:0] div, div_l, div_l_n, cnt, cnt_n, div_wr;
    logic [7:0] sh, sh_n;
    logic [2:0] bitc, bitc_n;
    logic [1:0] sel;
    logic [31:0] rdata;
    logic txd_n, ctrl_ie, ovf, full, empty, busy, wr, rd, pop, push_req, push, ovf_set, ovf_clr;
    logic unused_bits;
    assign unused_bits = ^{bus.MAddr, bus.MData, bus.MByteEn};
    assign sel = bus.MAddr[3:2];
    assign wr = bus.MCmd == 3'd1;
    assign rd = bus.MCmd == 3'd2;
    assign bus.SCmdAccept = wr | rd;
    assign count = wp - rp;
    assign empty = wp == rp;
    assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign busy = state != IDLE;
    assign pop = state == IDLE && !empty;
    assign push_req = wr && sel == 2'd0 && bus.MByteEn[0];
    // a pop in the same cycle frees the slot, so a write to a full FIFO still lands
    assign push = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;
    assign ovf_clr = wr && sel == 2'd1 && bus.MByteEn[0] && bus.MData[3];
    assign div_wr = {bus.MByteEn[1] ? bus.MData[15:8] : div[15:8], bus.MByteEn[0] ? bus.MData[7:0] : div[7:0]};
    assign rdata = sel == 2'd1 ? {16'd0, 8'(count), 4'd0, ovf, busy, empty, full} :
                   sel == 2'd2 ? {16'd0, div} :
                   sel == 2'd3 ? {31'd0, ctrl_ie} : 32'd0;

    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= bus.MData[7:0];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            div <= DIV_RESET;
            ctrl_ie <= 1'b0;
            ovf <= 1'b0;
            o_intr <= 1'b0;
            bus.SResp <= 2'd0;
            bus.SData <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (wr && sel == 2'd2 && |bus.MByteEn[1:0]) div <= div_wr == 16'd0 ? 16'd1 : div_wr;
            if (wr && sel == 2'd3 && bus.MByteEn[0]) ctrl_ie <= bus.MData[0];
            ovf <= ovf_set | (ovf & !ovf_clr);
            o_intr <= ctrl_ie & empty & !busy;
            bus.SResp <= {1'b0, bus.SCmdAccept};
            bus.SData <= rd ? rdata : '0;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bitc <= '0;
            sh <= '0;
            div_l <= '0;
            o_txd <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bitc <= bitc_n;
            sh <= sh_n;
            div_l <= div_l_n;
            o_txd <= txd_n;
        end

    // o_txd is registered: each branch sets the level the line takes on the next edge
    always_comb begin
        state_n = state;
        cnt_n = cnt - 16'd1;
        bitc_n = bitc;
        sh_n = sh;
        div_l_n = div_l;
        txd_n = o_txd;
        case (state)
            IDLE: if (pop) begin
                state_n = START;
                sh_n = mem[rp[AW-1:0]];
                div_l_n = div;
                cnt_n = div - 16'd1;
                txd_n = 1'b0;
            end else cnt_n = cnt;
            START: if (cnt == 16'd0) begin
                state_n = DATA;
                cnt_n = div_l - 16'd1;
                bitc_n = 3'd0;
                txd_n = sh[0];
            end
            DATA: if (cnt == 16'd0) begin
                cnt_n = div_l - 16'd1;
                if (bitc == 3'd7) begin
                    state_n = STOP;
                    txd_n = 1'b1;
                end else begin
                    bitc_n = bitc + 3'd1;
                    sh_n = sh >> 1;
                    txd_n = sh[1];
                end
            end
            STOP: if (cnt == 16'd0) begin
                state_n = IDLE;
                cnt_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: transmit FIFO entries; power of two, 2..64.
REQ-002 Parameter DIV_RESET, default 16'd16: divisor reset value, in clk cycles per bit.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_MAddr  in  ADDR_WIDTH  OCP address; only bits [3:2] decode the register.
REQ-006 i_MCmd  in  3  OCP command: IDLE, WRITE, READ; other encodings are treated as IDLE.
REQ-007 i_MData  in  DATA_WIDTH  OCP write data.
REQ-008 i_MByteEn  in  BEN_WIDTH  OCP byte enables.
REQ-009 o_SCmdAccept  out  1  command accept.
REQ-010 o_SData  out  DATA_WIDTH  read data.
REQ-011 o_SResp  out  2  OCP response: NULL or DVA.
REQ-012 o_txd  out  1  serial output; idles high.
REQ-013 o_intr  out  1  level interrupt.

Function
REQ-014 Register map by i_MAddr[3:2]:
- 0 = DATA (write only; reads return 0).
- 1 = STATUS (read; write-1-to-clear of bit3).
- 2 = DIVISOR, bits [15:0], read/write.
- 3 = CTRL, bit0 = IRQ enable, read/write.
REQ-015 o_SCmdAccept is combinationally 1 whenever i_MCmd is READ or WRITE; there are no wait states.
REQ-016 Every accepted command produces o_SResp = DVA exactly one cycle later, for one cycle; otherwise o_SResp = NULL.
REQ-017 For reads, o_SData carries the register value sampled at accept; in all other cycles o_SData is 0.
REQ-018 Register writes take effect only for byte lanes with i_MByteEn set.
REQ-019 DATA write with i_MByteEn[0] = 1 and FIFO not full: push i_MData[7:0].
REQ-020 DATA write with i_MByteEn[0] = 1 and FIFO full: discard the byte, set sticky overflow (STATUS bit3); the response is still DVA.
REQ-021 STATUS bits:
- bit0 = full.
- bit1 = empty.
- bit2 = busy (frame in progress).
- bit3 = overflow.
- [15:8] = FIFO count, zero-extended.
- all other bits 0.
REQ-022 Occupancy is tracked with wrap-around read/write pointers one bit wider than log2(FIFO_DEPTH).
REQ-023 A push and a pop in the same cycle leave the count unchanged, including when the FIFO is full (push accepted, overflow not set) and when it is empty.
REQ-024 A DIVISOR write of 0 stores 1.
REQ-025 A new divisor applies from the next frame start; the current frame completes at the old rate.
REQ-026 Transmit FSM states and transitions:
- IDLE: o_txd = 1. When the FIFO is non-empty, pop the head into the shift register, latch the divisor, go to START.
- START: o_txd = 0 for one bit period, then go to DATA.
- DATA: 8 bits, LSB first, each one bit period, tracked by a 3-bit bit counter; after bit 7 go to STOP.
- STOP: o_txd = 1 for one bit period, then go to IDLE.
REQ-027 Bit period is the latched divisor N clk cycles, counted by a 16-bit down-counter.
REQ-028 The pop happens in the IDLE cycle in which the FIFO is non-empty. o_txd falls on the following edge.
REQ-029 Back-to-back frames: from STOP, IDLE lasts exactly one cycle before the next START when data is waiting.
REQ-030 busy = 1 in START, DATA and STOP.
REQ-031 o_intr = CTRL.bit0 AND empty AND NOT busy, registered (one cycle after the condition).
REQ-032 A STATUS write with bit3 set and a same-cycle overflow event: the overflow wins and bit3 stays 1.

Reset
REQ-033 Asserting rst asynchronously sets:
- FIFO empty, pointers 0.
- DIVISOR = DIV_RESET, CTRL = 0, overflow = 0.
- FSM = IDLE, counters 0.
- o_txd = 1, o_intr = 0, o_SResp = NULL, o_SData = 0.
REQ-034 Reset mid-frame aborts the frame: o_txd goes high immediately and queued data is lost.
REQ-035 The first command is accepted in the first cycle after rst deasserts.

Verification
REQ-036 Post-reset read of STATUS, then DIVISOR -> 0x0000_0002 and 0x0000_0010; o_txd = 1.
REQ-037 DIVISOR = 4, write DATA 0x21 -> o_txd: start low for 4 cycles, then bits 1,0,0,0,0,1,0,0 at 4 cycles each, then stop high for 4 cycles; busy clears after 40 cycles from the first low.
REQ-038 DIVISOR = 2, write 9 bytes back-to-back while idle -> STATUS after the 9th write shows full = 1, overflow = 0. This works because the 1st byte was popped before the 9th write. A 10th write sets overflow = 1; writing 0x8 to STATUS clears it.
REQ-039 CTRL = 1, send one byte with DIVISOR = 1 -> o_intr = 0 while busy; o_intr = 1 one cycle after the frame ends; o_intr = 0 one cycle after the next DATA push.
REQ-040 DATA write with i_MByteEn = 4'h0 -> no push, STATUS unchanged, response DVA.
REQ-041 Assert rst during DATA bit 3 with 2 bytes queued -> o_txd = 1 asynchronously; after release STATUS = 0x0000_0002 and no further frames.
